bist_transmitter: RTL and testbench

- Upstream stage of the link BIST receiver. Sits on the driving side of a TEST_CHANNELS-wide point-to-point link.
- After reset it drives the LFSR pattern onto the link for TEST_CASES cycles. It then waits for the receiver's verdict.
- On pass it hands the link to mission traffic. On fail or timeout it parks the link at zero and flags the error.

---
 rtl/bist_pkg.sv | 17 +
 rtl/lfsr.sv | 30 +++
 rtl/bist_transmitter.sv | 126 ++++++++++++
 tb/tb_bist_transmitter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and defaults for the link BIST transmitter/receiver pair.
// Both ends must agree on the LFSR width, seed, polynomial and test length.
`timescale 1ns/1ps
package bist_pkg;

    typedef enum logic [1:0] {TEST, WAIT, MISSION, FAIL} bist_tx_state_t;

    localparam int                BIST_LFSR_W     = 32;
    localparam logic [31:0]       BIST_SEED       = 32'hdeadbeef;
    localparam int                BIST_TEST_CASES = 1000;

    // Fibonacci feedback for x^32 + x^22 + x^2 + x + 1.
    function automatic logic lfsr_feedback(input logic [BIST_LFSR_W-1:0] s);
        return s[31] ^ s[21] ^ s[1] ^ s[0];
    endfunction

endpackage

// File: rtl/lfsr.sv
// 32-bit Fibonacci LFSR with asynchronous reset to SEED.
// A load port lets the owner overwrite (or hold) the state for a cycle.
`timescale 1ns/1ps
module lfsr
    import bist_pkg::*;
#(
    parameter logic [BIST_LFSR_W-1:0] SEED = BIST_SEED
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [BIST_LFSR_W-1:0] load_value,
    output logic [BIST_LFSR_W-1:0] state
);

    logic [BIST_LFSR_W-1:0] state_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SEED;
        end else if (load) begin
            state_reg <= load_value;
        end else begin
            state_reg <= {state_reg[BIST_LFSR_W-2:0], lfsr_feedback(state_reg)};
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/bist_transmitter.sv
// Driving side of the link BIST: LFSR pattern for TEST_CASES cycles, then verdict,
// then mission pass-through or parked link. Optional: BIST_TRANSMITTER_FAULT_INJECT_EN.
`timescale 1ns/1ps
module bist_transmitter
    import bist_pkg::*;
#(
    parameter int                     TEST_CHANNELS = 70,
    parameter logic [BIST_LFSR_W-1:0] SEED          = BIST_SEED,
    parameter int                     TEST_CASES    = BIST_TEST_CASES,
    parameter int                     TIMEOUT       = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [TEST_CHANNELS-1:0] func_channels,
    input  logic                     rx_ready,
    input  logic                     rx_failed,
    output logic [TEST_CHANNELS-1:0] tx_channels,
    output logic                     testing,
    output logic                     link_up,
    output logic                     error,
    output logic                     timeout
`ifdef BIST_TRANSMITTER_FAULT_INJECT_EN
    ,
    input  logic                     inject_fault
`endif
);

    bist_tx_state_t         state_reg;
    bist_tx_state_t         state_next;
    logic [31:0]            case_cnt_reg;
    logic [31:0]            wait_cnt_reg;
    logic                   timeout_reg;
    logic                   timeout_set;
    logic [BIST_LFSR_W-1:0] lfsr_state;
    logic [TEST_CHANNELS-1:0] pattern;

    // Outside TEST the LFSR reloads its own value, i.e. holds.
    lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      (state_reg != TEST),
        .load_value(lfsr_state),
        .state     (lfsr_state)
    );

    // Zero-extend or truncate the LFSR onto the link width.
    generate
        for (genvar gi = 0; gi < TEST_CHANNELS; gi++) begin : g_pattern
            if (gi < BIST_LFSR_W) begin : g_lfsr_bit
                assign pattern[gi] = lfsr_state[gi];
            end else begin : g_zero_bit
                assign pattern[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= TEST;
            case_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == TEST) begin
                case_cnt_reg <= case_cnt_reg + 32'd1;
            end
            if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 32'd1;
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        timeout_set = 1'b0;
        case (state_reg)
            TEST: begin
                if (case_cnt_reg == 32'(TEST_CASES - 1)) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A verdict on the same cycle as the timeout wins.
                if (rx_ready) begin
                    state_next = rx_failed ? FAIL : MISSION;
                end else if (wait_cnt_reg == 32'(TIMEOUT - 1)) begin
                    state_next  = FAIL;
                    timeout_set = 1'b1;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    always_comb begin
        tx_channels = '0;
        testing     = 1'b0;
        link_up     = 1'b0;
        error       = 1'b0;
        case (state_reg)
            TEST: begin
                testing     = 1'b1;
                tx_channels = pattern;
`ifdef BIST_TRANSMITTER_FAULT_INJECT_EN
                tx_channels[0] = pattern[0] ^ inject_fault;
`endif
            end
            WAIT:    testing = 1'b1;
            MISSION: begin
                link_up     = 1'b1;
                tx_channels = func_channels;
            end
            FAIL:    error = 1'b1;
            default: tx_channels = '0;
        endcase
    end

    assign timeout = timeout_reg;

endmodule

// File: tb/tb_bist_transmitter.sv
// Scoreboard bench for bist_transmitter: the stimulus process queues expected outputs
// per cycle, a negedge monitor pops and compares a 70-bit and a 16-bit instance.
`timescale 1ns/1ps
module tb_bist_transmitter;

    localparam int          W     = 70;
    localparam int          NW    = 16;
    localparam int          CASES = 8;
    localparam int          TMO   = 4;
    localparam logic [31:0] SEED_V = 32'hdeadbeef;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_ready = 1'b0;
    logic          rx_failed = 1'b0;
    logic [W-1:0]  func_channels = '0;
    logic [W-1:0]  tx_channels;
    logic          testing, link_up, error, timeout;
    logic [NW-1:0] tx_n;
    logic          testing_n, link_up_n, error_n, timeout_n;
`ifdef BIST_TRANSMITTER_FAULT_INJECT_EN
    logic          inject_fault = 1'b0;
`endif

    always #5 clk = ~clk;

    bist_transmitter #(
        .TEST_CHANNELS(W), .SEED(SEED_V), .TEST_CASES(CASES), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .func_channels(func_channels),
        .rx_ready(rx_ready), .rx_failed(rx_failed), .tx_channels(tx_channels),
        .testing(testing), .link_up(link_up), .error(error), .timeout(timeout)
`ifdef BIST_TRANSMITTER_FAULT_INJECT_EN
        , .inject_fault(inject_fault)
`endif
    );

    bist_transmitter #(
        .TEST_CHANNELS(NW), .SEED(SEED_V), .TEST_CASES(CASES), .TIMEOUT(TMO)
    ) dut_narrow (
        .clk(clk), .reset(reset), .func_channels(func_channels[NW-1:0]),
        .rx_ready(rx_ready), .rx_failed(rx_failed), .tx_channels(tx_n),
        .testing(testing_n), .link_up(link_up_n), .error(error_n), .timeout(timeout_n)
`ifdef BIST_TRANSMITTER_FAULT_INJECT_EN
        , .inject_fault(inject_fault)
`endif
    );

    typedef struct {
        string        name;
        logic [W-1:0] tx;
        logic         testing;
        logic         link_up;
        logic         error;
        logic         timeout;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] model;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [W-1:0] ext(input logic [31:0] s);
        logic [W-1:0] x;
        x = '0;
        x[31:0] = s;
        return x;
    endfunction

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic expect_cycle(input string name, input logic [W-1:0] tx,
                                input logic t, input logic l, input logic e, input logic to);
        exp_t x;
        x.name = name; x.tx = tx; x.testing = t; x.link_up = l; x.error = e; x.timeout = to;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_ready = 1'b0;
        rx_failed = 1'b0;
        expect_cycle("reset", ext(SEED_V), 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        model = SEED_V;
    endtask

    // Drive n TEST cycles; rx_failed toggles to show it is ignored during TEST.
    task automatic run_test(input int n, input int fault_at);
        logic [W-1:0] t;
        for (int k = 0; k < n; k++) begin
            rx_failed = k[0];
            t = ext(model);
`ifdef BIST_TRANSMITTER_FAULT_INJECT_EN
            inject_fault = (k == fault_at);
            if (k == fault_at) t[0] = ~t[0];
`else
            if (k == fault_at) t = ext(model);
`endif
            expect_cycle($sformatf("test_k%0d", k), t, 1'b1, 1'b0, 1'b0, 1'b0);
            model = lfsr_step(model);
        end
        rx_failed = 1'b0;
`ifdef BIST_TRANSMITTER_FAULT_INJECT_EN
        inject_fault = 1'b0;
`endif
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            if ({tx_channels, testing, link_up, error, timeout} !==
                {mon_e.tx, mon_e.testing, mon_e.link_up, mon_e.error, mon_e.timeout}) begin
                bad++;
                $display("FAIL %s: got tx=%h t/l/e/to=%b%b%b%b want tx=%h t/l/e/to=%b%b%b%b",
                         mon_e.name, tx_channels, testing, link_up, error, timeout,
                         mon_e.tx, mon_e.testing, mon_e.link_up, mon_e.error, mon_e.timeout);
            end else begin
                $display("ok %s tx=%h t/l/e/to=%b%b%b%b", mon_e.name, tx_channels,
                         testing, link_up, error, timeout);
            end
            total++;
            if ({tx_n, testing_n, link_up_n, error_n, timeout_n} !==
                {mon_e.tx[NW-1:0], mon_e.testing, mon_e.link_up, mon_e.error, mon_e.timeout}) begin
                bad++;
                $display("FAIL %s_narrow: got tx=%h t/l/e/to=%b%b%b%b want tx=%h t/l/e/to=%b%b%b%b",
                         mon_e.name, tx_n, testing_n, link_up_n, error_n, timeout_n,
                         mon_e.tx[NW-1:0], mon_e.testing, mon_e.link_up, mon_e.error,
                         mon_e.timeout);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;

        // Pass path: verdict ok, then combinational mission pass-through.
        do_reset();
        run_test(CASES, -1);
        expect_cycle("pass_wait0", '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_ready = 1'b1; rx_failed = 1'b0;
        expect_cycle("pass_verdict", '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_ready = 1'b0;
        func_channels = 70'h3;
        expect_cycle("mission_h3", 70'h3, 1'b0, 1'b1, 1'b0, 1'b0);
        func_channels = 70'h3F0123456789ABCDEF;
        rx_ready = 1'b1; rx_failed = 1'b1;
        expect_cycle("mission_hold", 70'h3F0123456789ABCDEF, 1'b0, 1'b1, 1'b0, 1'b0);

        // Fail path: link parked while func toggles.
        do_reset();
        run_test(CASES, -1);
        rx_ready = 1'b1; rx_failed = 1'b1;
        expect_cycle("fail_verdict", '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_ready = 1'b0; rx_failed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            func_channels = ~func_channels;
            expect_cycle("fail_hold", '0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Timeout: exactly TMO wait cycles, then sticky timeout.
        do_reset();
        run_test(CASES, -1);
        for (int i = 0; i < TMO; i++) begin
            expect_cycle($sformatf("to_wait%0d", i), '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        rx_ready = 1'b1;
        expect_cycle("timeout_fail", '0, 1'b0, 1'b0, 1'b1, 1'b1);
        rx_ready = 1'b0;
        expect_cycle("timeout_hold", '0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Verdict on the last wait cycle beats the timeout.
        do_reset();
        run_test(CASES, -1);
        for (int i = 0; i < TMO - 1; i++) begin
            expect_cycle($sformatf("prio_wait%0d", i), '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        rx_ready = 1'b1; rx_failed = 1'b0;
        expect_cycle("prio_verdict", '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_ready = 1'b0;
        func_channels = 70'h155;
        expect_cycle("prio_mission", 70'h155, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset at case 5 restarts the full sequence from SEED.
        do_reset();
        run_test(5, -1);
        do_reset();
        run_test(CASES, -1);
        expect_cycle("restart_wait", '0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef BIST_TRANSMITTER_FAULT_INJECT_EN
        // Bit-0 corruption at case 3; bench-as-receiver then reports failure.
        do_reset();
        run_test(CASES, 3);
        rx_ready = 1'b1; rx_failed = 1'b1;
        expect_cycle("inject_verdict", '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_ready = 1'b0; rx_failed = 1'b0;
        expect_cycle("inject_fail", '0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
